// File: rtl/brq_pkg.sv
// Shared definitions for the brq register file with scoreboard.
// Contents:
//   brq_state_e      - sequencing state (INIT sweep / RUN traffic)
//   SP_IDX_DEFAULT   - register index holding the stack pointer
//   SP_INIT_DEFAULT  - stack-pointer value loaded by the INIT sweep
//   DBG_IDX_DEFAULT  - register mirrored on dbg_out
package brq_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } brq_state_e;

    localparam int          SP_IDX_DEFAULT  = 2;
    localparam logic [31:0] SP_INIT_DEFAULT = 32'h0000_0200;
    localparam int          DBG_IDX_DEFAULT = 15;

endpackage

// File: rtl/brq_scoreboard.sv
// Busy-bit scoreboard for long-latency destinations.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset (clears all busy bits)
//   set_en/addr   - mark a destination busy at the next edge (index 0 ignored)
//   clr_en/addr   - clear a destination's busy bit at the next edge
//   lookup_addr   - NumRead indices to look up
//   lookup_busy   - registered busy bit of each lookup index (no bypass)
module brq_scoreboard #(
    parameter int AddrRegWidth = 5,
    parameter int NumRead      = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  set_en,
    input  logic [AddrRegWidth-1:0]               set_addr,
    input  logic                                  clr_en,
    input  logic [AddrRegWidth-1:0]               clr_addr,
    input  logic [NumRead-1:0][AddrRegWidth-1:0]  lookup_addr,
    output logic [NumRead-1:0]                    lookup_busy
);

    localparam int NReg = 2**AddrRegWidth;

    logic [NReg-1:0] busy_reg;
    logic [NReg-1:0] busy_next;

    // Clear is applied first so that a simultaneous set on the same index wins.
    always_comb begin
        busy_next = busy_reg;
        if (clr_en) begin
            busy_next[clr_addr] = 1'b0;
        end
        if (set_en && (set_addr != '0)) begin
            busy_next[set_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    genvar gi;
    for (gi = 0; gi < NumRead; gi++) begin : g_lookup
        assign lookup_busy[gi] = busy_reg[lookup_addr[gi]];
    end

endmodule

// File: rtl/brq_regfile_sb.sv
// Multi-ported register file with write-to-read forwarding and a busy
// scoreboard for long-latency writeback. After reset the array is swept one
// register per cycle (stack pointer loaded, everything else zeroed) before
// traffic is accepted.
// Ports:
//   brq_clk, brq_rst_n      - clock, asynchronous active-low reset
//   rd_addr / rd_data       - NumRead combinational read ports
//   rd_busy                 - scoreboard busy bit of each rd_addr
//   wr_en/wr_addr/wr_data   - NumWrite write ports; last port is long-latency
//   sb_set / sb_addr        - mark a destination busy
//   init_done               - high once the sweep is finished
//   dbg_out                 - contents of register DbgIdx
module brq_regfile_sb
    import brq_pkg::*;
#(
    parameter int                   DataWidth    = 32,
    parameter int                   AddrRegWidth = 5,
    parameter int                   NumRead      = 2,
    parameter int                   NumWrite     = 2,
    parameter bit                   Bypass       = 1'b1,
    parameter int                   SpIdx        = SP_IDX_DEFAULT,
    parameter logic [DataWidth-1:0] SpInit       = DataWidth'(SP_INIT_DEFAULT),
    parameter int                   DbgIdx       = DBG_IDX_DEFAULT
) (
    input  logic                                  brq_clk,
    input  logic                                  brq_rst_n,
    input  logic [NumRead-1:0][AddrRegWidth-1:0]  rd_addr,
    output logic [NumRead-1:0][DataWidth-1:0]     rd_data,
    output logic [NumRead-1:0]                    rd_busy,
    input  logic [NumWrite-1:0]                   wr_en,
    input  logic [NumWrite-1:0][AddrRegWidth-1:0] wr_addr,
    input  logic [NumWrite-1:0][DataWidth-1:0]    wr_data,
    input  logic                                  sb_set,
    input  logic [AddrRegWidth-1:0]               sb_addr,
    output logic                                  init_done,
    output logic [DataWidth-1:0]                  dbg_out
);

    localparam int NReg = 2**AddrRegWidth;

    brq_state_e              state_reg, state_next;
    logic [AddrRegWidth-1:0] cnt_reg, cnt_next;
    logic                    run;

    always_ff @(posedge brq_clk or negedge brq_rst_n) begin
        if (!brq_rst_n) begin
            state_reg <= INIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            INIT: begin
                cnt_next = cnt_reg + AddrRegWidth'(1);
                if (cnt_reg == AddrRegWidth'(NReg - 1)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    assign run       = (state_reg == RUN);
    assign init_done = run;

    // Per-register view: what a reader sees this cycle (0 during the sweep,
    // the winning write data when forwarding, otherwise the stored value).
    logic [DataWidth-1:0] view [NReg];

    assign view[0] = '0;

    genvar gi;
    for (gi = 1; gi < NReg; gi++) begin : g_reg
        logic                 we;
        logic [DataWidth-1:0] wd;
        logic [DataWidth-1:0] q_reg;

        // Ascending port scan: the highest-numbered matching port wins.
        always_comb begin
            we = 1'b0;
            wd = '0;
            if (!run) begin
                if (cnt_reg == AddrRegWidth'(gi)) begin
                    we = 1'b1;
                    wd = (gi == SpIdx) ? SpInit : '0;
                end
            end else begin
                for (int p = 0; p < NumWrite; p++) begin
                    if (wr_en[p] && (wr_addr[p] == AddrRegWidth'(gi))) begin
                        we = 1'b1;
                        wd = wr_data[p];
                    end
                end
            end
        end

        // Storage has no reset; the sweep provides the initial contents.
        always_ff @(posedge brq_clk) begin
            if (we) begin
                q_reg <= wd;
            end
        end

        assign view[gi] = !run ? '0 : ((Bypass && we) ? wd : q_reg);
    end

    for (gi = 0; gi < NumRead; gi++) begin : g_read
        assign rd_data[gi] = view[rd_addr[gi]];
    end

    assign dbg_out = view[DbgIdx];

    logic [NumRead-1:0] lookup_busy;

    brq_scoreboard #(
        .AddrRegWidth (AddrRegWidth),
        .NumRead      (NumRead)
    ) u_scoreboard (
        .clk         (brq_clk),
        .rst_n       (brq_rst_n),
        .set_en      (run && sb_set),
        .set_addr    (sb_addr),
        .clr_en      (run && wr_en[NumWrite-1]),
        .clr_addr    (wr_addr[NumWrite-1]),
        .lookup_addr (rd_addr),
        .lookup_busy (lookup_busy)
    );

    assign rd_busy = run ? lookup_busy : '0;

endmodule

// File: tb/tb_brq_regfile_sb.sv
// Self-checking bench for brq_regfile_sb: one instance with forwarding, one
// without, sharing all stimulus. A behavioural model (plain arrays and a
// cycle count since reset release) predicts every output on every cycle;
// directed steps add literal expectations for the key scenarios.
module tb_brq_regfile_sb;

    logic              brq_clk   = 1'b0;
    logic              brq_rst_n = 1'b0;
    logic [1:0][4:0]   rd_addr;
    logic [1:0]        wr_en;
    logic [1:0][4:0]   wr_addr;
    logic [1:0][31:0]  wr_data;
    logic              sb_set;
    logic [4:0]        sb_addr;

    logic [1:0][31:0]  rd_data_a, rd_data_b;
    logic [1:0]        rd_busy_a, rd_busy_b;
    logic              init_done_a, init_done_b;
    logic [31:0]       dbg_a, dbg_b;

    int n_pass  = 0;
    int n_total = 0;

    always #5 brq_clk = ~brq_clk;

    brq_regfile_sb #(.Bypass(1'b1)) dut_a (
        .brq_clk   (brq_clk),
        .brq_rst_n (brq_rst_n),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data_a),
        .rd_busy   (rd_busy_a),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .sb_set    (sb_set),
        .sb_addr   (sb_addr),
        .init_done (init_done_a),
        .dbg_out   (dbg_a)
    );

    brq_regfile_sb #(.Bypass(1'b0)) dut_b (
        .brq_clk   (brq_clk),
        .brq_rst_n (brq_rst_n),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data_b),
        .rd_busy   (rd_busy_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .sb_set    (sb_set),
        .sb_addr   (sb_addr),
        .init_done (init_done_b),
        .dbg_out   (dbg_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mreg  [32];
    bit          mbusy [32];
    int          mcyc = 0;   // cycles since reset release, saturating at 32

    always @(posedge brq_clk or negedge brq_rst_n) begin
        if (!brq_rst_n) begin
            mcyc = 0;
            foreach (mbusy[k]) mbusy[k] = 1'b0;
        end else if (mcyc < 32) begin
            mreg[mcyc] = (mcyc == 2) ? 32'h0000_0200 : 32'h0;
            mcyc++;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (wr_en[p] && wr_addr[p] != 5'd0) mreg[wr_addr[p]] = wr_data[p];
            end
            if (wr_en[1]) mbusy[wr_addr[1]] = 1'b0;
            if (sb_set && sb_addr != 5'd0) mbusy[sb_addr] = 1'b1;
        end
    end

    function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
        if (mcyc < 32 || a == 5'd0) return 32'h0;
        if (byp) begin
            for (int p = 1; p >= 0; p--) begin
                if (wr_en[p] && wr_addr[p] == a) return wr_data[p];
            end
        end
        return mreg[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (mcyc < 32) return 1'b0;
        return mbusy[a];
    endfunction

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge brq_clk);
            #2;
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("rd_data_a[%0d]", i), rd_data_a[i], exp_read(rd_addr[i], 1'b1));
                chk($sformatf("rd_data_b[%0d]", i), rd_data_b[i], exp_read(rd_addr[i], 1'b0));
                chk($sformatf("rd_busy_a[%0d]", i), {31'b0, rd_busy_a[i]}, {31'b0, exp_busy(rd_addr[i])});
                chk($sformatf("rd_busy_b[%0d]", i), {31'b0, rd_busy_b[i]}, {31'b0, exp_busy(rd_addr[i])});
            end
            chk("init_done_a", {31'b0, init_done_a}, {31'b0, (mcyc == 32)});
            chk("init_done_b", {31'b0, init_done_b}, {31'b0, (mcyc == 32)});
            chk("dbg_a", dbg_a, exp_read(5'd15, 1'b1));
            chk("dbg_b", dbg_b, exp_read(5'd15, 1'b0));
        end
    end

    task automatic drive_idle();
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        sb_set  = 1'b0;
        sb_addr = '0;
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (init_done_a !== 1'b1 && n < 100) begin
            @(posedge brq_clk);
            #1;
            n++;
        end
        chk(name, 32'(n), 32'd32);
        $display("%s: init_done after %0d cycles", name, n);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        rd_addr = '0;
        drive_idle();
        repeat (3) @(negedge brq_clk);
        #3;
        chk("reset_init_done", {31'b0, init_done_a}, 32'h0);
        chk("reset_rd_data", rd_data_a[0], 32'h0);

        @(negedge brq_clk);
        brq_rst_n = 1'b1;
        wait_init("init_low_cycles");

        for (int r = 0; r < 32; r++) begin
            @(negedge brq_clk);
            rd_addr[0] = 5'(r);
            rd_addr[1] = 5'(31 - r);
            #3;
            chk($sformatf("init_reg%0d", r), rd_data_b[0], (r == 2) ? 32'h0000_0200 : 32'h0);
        end
        $display("readback of swept registers done");

        @(negedge brq_clk);
        wr_en = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEAD_BEEF; rd_addr[0] = 5'd5;
        #3;
        chk("bypass_same_cycle", rd_data_a[0], 32'hDEAD_BEEF);
        chk("nobypass_same_cycle", rd_data_b[0], 32'h0);
        @(negedge brq_clk);
        drive_idle();
        #3;
        chk("nobypass_next_cycle", rd_data_b[0], 32'hDEAD_BEEF);
        $display("write p0 idx5 data deadbeef");

        @(negedge brq_clk);
        wr_en = 2'b11; wr_addr[0] = 5'd7; wr_addr[1] = 5'd7;
        wr_data[0] = 32'h1; wr_data[1] = 32'h2; rd_addr[0] = 5'd7;
        #3;
        chk("collision_bypass", rd_data_a[0], 32'h2);
        @(negedge brq_clk);
        drive_idle();
        #3;
        chk("collision_a", rd_data_a[0], 32'h2);
        chk("collision_b", rd_data_b[0], 32'h2);
        $display("write p0+p1 idx7 data 1/2");

        @(negedge brq_clk);
        wr_en = 2'b11; wr_addr = '0; wr_data[0] = 32'hFFFF_FFFF; wr_data[1] = 32'hFFFF_FFFF;
        rd_addr[0] = 5'd0;
        #3;
        chk("zero_same_cycle", rd_data_a[0], 32'h0);
        @(negedge brq_clk);
        drive_idle();
        #3;
        chk("zero_after_a", rd_data_a[0], 32'h0);
        chk("zero_after_b", rd_data_b[0], 32'h0);
        $display("write idx0 data ffffffff");

        @(negedge brq_clk);
        sb_set = 1'b1; sb_addr = 5'd9; rd_addr[1] = 5'd9;
        #3;
        chk("busy_not_forwarded", {31'b0, rd_busy_a[1]}, 32'h0);
        @(negedge brq_clk);
        drive_idle();
        #3;
        chk("busy_set", {31'b0, rd_busy_a[1]}, 32'h1);
        @(negedge brq_clk);
        wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'h55;
        @(negedge brq_clk);
        drive_idle();
        #3;
        chk("busy_kept_by_port0", {31'b0, rd_busy_a[1]}, 32'h1);
        @(negedge brq_clk);
        wr_en = 2'b10; wr_addr[1] = 5'd9; wr_data[1] = 32'h99;
        #3;
        chk("busy_during_clear", {31'b0, rd_busy_a[1]}, 32'h1);
        @(negedge brq_clk);
        drive_idle();
        #3;
        chk("busy_cleared", {31'b0, rd_busy_a[1]}, 32'h0);
        @(negedge brq_clk);
        sb_set = 1'b1; sb_addr = 5'd9; wr_en = 2'b10; wr_addr[1] = 5'd9; wr_data[1] = 32'h77;
        @(negedge brq_clk);
        drive_idle();
        #3;
        chk("set_wins_over_clear", {31'b0, rd_busy_b[1]}, 32'h1);
        @(negedge brq_clk);
        sb_set = 1'b1; sb_addr = 5'd0; rd_addr[0] = 5'd0;
        @(negedge brq_clk);
        drive_idle();
        #3;
        chk("busy_reg0", {31'b0, rd_busy_a[0]}, 32'h0);
        $display("scoreboard set/clear on idx9 done");

        @(negedge brq_clk);
        wr_en = 2'b01; wr_addr[0] = 5'd15; wr_data[0] = 32'hA5A5_A5A5;
        #3;
        chk("dbg_bypass", dbg_a, 32'hA5A5_A5A5);
        chk("dbg_nobypass_old", dbg_b, 32'h0);
        @(negedge brq_clk);
        drive_idle();
        #3;
        chk("dbg_nobypass_next", dbg_b, 32'hA5A5_A5A5);
        $display("write p0 idx15 data a5a5a5a5");

        // Reset mid-sweep at sweep count 10, busy[9] still set beforehand.
        @(negedge brq_clk);
        brq_rst_n = 1'b0;
        #3;
        chk("reset_clears_busy", {31'b0, rd_busy_a[1]}, 32'h0);
        chk("reset_init_done_low", {31'b0, init_done_a}, 32'h0);
        @(negedge brq_clk);
        brq_rst_n = 1'b1;
        repeat (10) @(posedge brq_clk);
        @(negedge brq_clk);
        brq_rst_n = 1'b0;
        @(negedge brq_clk);
        brq_rst_n = 1'b1;
        wait_init("init_low_after_midsweep_reset");
        @(negedge brq_clk);
        rd_addr[0] = 5'd2; rd_addr[1] = 5'd9;
        #3;
        chk("busy9_after_reset", {31'b0, rd_busy_a[1]}, 32'h0);
        chk("reg9_reswept", rd_data_a[1], 32'h0);
        chk("reg2_reswept", rd_data_b[0], 32'h0000_0200);

        for (int c = 0; c < 2500; c++) begin
            bit narrow;
            @(negedge brq_clk);
            narrow = ($urandom_range(0, 3) == 0);
            brq_rst_n = (c == 1200) ? 1'b0 : 1'b1;
            for (int p = 0; p < 2; p++) begin
                wr_addr[p] = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
                wr_data[p] = $urandom;
                rd_addr[p] = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
            end
            wr_en   = 2'($urandom);
            sb_set  = ($urandom_range(0, 3) == 0);
            sb_addr = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
        end
        $display("random traffic phase done");

        @(negedge brq_clk);
        drive_idle();
        @(negedge brq_clk);
        #5;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
